// File: rtl/sisc_fetch.sv
// sisc_fetch: SISC instruction fetch unit (PC owner, imem req/ack master, ir producer).
// Latency: ir_valid rises on the edge that ends the imem ack cycle (1 cycle after req at zero wait).
// Backpressure: no new request while ir (or, with prefetch, the buffer) is full; a request is held until acked.
//
// Optional feature macro: FETCH_PREFETCH_EN adds a one-entry prefetch buffer so
// fetching continues while ir is occupied (1 instr/cycle at zero-wait memory).
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   imem_req, imem_addr    registered fetch request and word address
//   imem_ack, imem_rdata   memory acknowledge (may be same cycle as req) and data
//   ir, ir_valid, pc       instruction register, live flag, address of ir
//   ir_take                consumer accepts ir (ignored while ir_valid=0)
//   br_taken, br_target    single-cycle redirect and its target address

module sisc_fetch #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       ir,
   output logic              ir_valid,
   input  logic              ir_take,
   output logic [ADDR_W-1:0] pc,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   localparam logic [ADDR_W-1:0] PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [1:0]        state,    state_n;
   logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
   logic              squash,   squash_n;
   logic [31:0]       ir_n;
   logic [ADDR_W-1:0] pc_n;
   logic              ir_valid_n;
   logic              req_n;
   logic [ADDR_W-1:0] addr_n;

`ifdef FETCH_PREFETCH_EN
   logic [31:0]       buf_dat,   buf_dat_n;
   logic [ADDR_W-1:0] buf_pc,    buf_pc_n;
   logic              buf_valid, buf_valid_n;
`endif

   logic take;       // consumer handshake actually completes this cycle
   logic ack_live;   // ack belongs to our outstanding request
   logic ack_use;    // acked data is kept (not squashed, not overtaken by a branch)
   logic can_req;    // there will be room for another word after this edge
   logic new_req;    // a fresh request (new address) starts next cycle

   assign take     = ir_take & ir_valid;
   // imem_req is only ever high in S_REQ, so an ack seen in IDLE/HOLD
   // (e.g. a late ack after reset) falls out here.
   assign ack_live = imem_req & imem_ack;
   assign ack_use  = ack_live & ~squash & ~br_taken;

   always_comb begin
      state_n    = state;
      fetch_pc_n = fetch_pc;
      squash_n   = squash;
      ir_n       = ir;
      pc_n       = pc;
      ir_valid_n = ir_valid;
      req_n      = imem_req;
      addr_n     = imem_addr;
      can_req    = 1'b0;
      new_req    = 1'b0;
`ifdef FETCH_PREFETCH_EN
      buf_dat_n   = buf_dat;
      buf_pc_n    = buf_pc;
      buf_valid_n = buf_valid;
`endif

      // Consumer side: ir empties, or is refilled from the buffer.
      if (take) begin
         ir_valid_n = 1'b0;
`ifdef FETCH_PREFETCH_EN
         if (buf_valid) begin
            ir_n        = buf_dat;
            pc_n        = buf_pc;
            ir_valid_n  = 1'b1;
            buf_valid_n = 1'b0;
         end
`endif
      end

      // Memory side. While requesting, the buffer is always empty, so acked
      // data goes to ir when ir frees up this edge, otherwise to the buffer.
      if (ack_use) begin
         fetch_pc_n = fetch_pc + PC_INC;
`ifdef FETCH_PREFETCH_EN
         if (!ir_valid || (take && !buf_valid)) begin
            ir_n       = imem_rdata;
            pc_n       = fetch_pc;
            ir_valid_n = 1'b1;
         end else begin
            buf_dat_n   = imem_rdata;
            buf_pc_n    = fetch_pc;
            buf_valid_n = 1'b1;
         end
`else
         ir_n       = imem_rdata;
         pc_n       = fetch_pc;
         ir_valid_n = 1'b1;
`endif
      end

      // Any ack retires the outstanding request, squashed or not.
      if (ack_live) begin
         squash_n = 1'b0;
      end

      // Redirect overrides everything above. An unacked request cannot be
      // withdrawn, so its eventual data is marked for discard instead.
      if (br_taken) begin
         fetch_pc_n = br_target;
         ir_valid_n = 1'b0;
`ifdef FETCH_PREFETCH_EN
         buf_valid_n = 1'b0;
`endif
         if (imem_req && !imem_ack) begin
            squash_n = 1'b1;
         end
      end

`ifdef FETCH_PREFETCH_EN
      can_req = ~buf_valid_n;
`else
      can_req = ~ir_valid_n;
`endif

      case (state)
         S_IDLE: state_n = S_REQ;
         S_REQ: begin
            if (imem_ack) begin
               state_n = can_req ? S_REQ : S_HOLD;
            end
         end
         S_HOLD: state_n = can_req ? S_REQ : S_HOLD;
         default: state_n = S_IDLE;
      endcase

      // An unacked request keeps its address; anything else entering REQ
      // issues a new request at the (possibly redirected) fetch_pc.
      new_req = (state_n == S_REQ) && !((state == S_REQ) && !imem_ack);
      req_n   = (state_n == S_REQ);
      if (new_req) begin
         addr_n = fetch_pc_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         fetch_pc  <= RESET_PC;
         squash    <= 1'b0;
         ir        <= 32'h0;
         pc        <= RESET_PC;
         ir_valid  <= 1'b0;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
`ifdef FETCH_PREFETCH_EN
         buf_dat   <= 32'h0;
         buf_pc    <= RESET_PC;
         buf_valid <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         fetch_pc  <= fetch_pc_n;
         squash    <= squash_n;
         ir        <= ir_n;
         pc        <= pc_n;
         ir_valid  <= ir_valid_n;
         imem_req  <= req_n;
         imem_addr <= addr_n;
`ifdef FETCH_PREFETCH_EN
         buf_dat   <= buf_dat_n;
         buf_pc    <= buf_pc_n;
         buf_valid <= buf_valid_n;
`endif
      end
   end

endmodule

// File: tb/tb_sisc_fetch.sv
// tb_sisc_fetch: self-checking bench for sisc_fetch.
// Memory model returns 32'h1000_0000+addr with programmable wait, per-address hold and late-ack injection.
// Expected {pc, ir} pairs are queued as stimulus is set up and popped on each consumer take.

module tb_sisc_fetch;

   typedef struct packed {
      logic [15:0] pc;
      logic [31:0] ir;
   } exp_t;

`ifdef FETCH_PREFETCH_EN
   localparam int SPACING    = 1;
   localparam int STALL_REQS = 1;
`else
   localparam int SPACING    = 2;
   localparam int STALL_REQS = 0;
`endif

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] ir;
   logic        ir_valid;
   logic        ir_take;
   logic [15:0] pc;
   logic        br_taken;
   logic [15:0] br_target;

   // second instance for the reset-PC wrap case
   logic        req2;
   logic [15:0] addr2;
   logic        ack2;
   logic [31:0] rdata2;
   logic [31:0] ir2;
   logic        ir_valid2;
   logic [15:0] pc2;

   // memory model controls
   int          lat;
   int          wcnt;
   logic        hold_en;
   logic [15:0] hold_addr;
   logic        force_ack;
   logic        ovr_en;
   logic [31:0] ovr_dat;

   // bookkeeping (all owned by the main process)
   exp_t        sb[$];
   int          vectors;
   int          miscompares;
   int          cyc;
   int          rel;
   int          n_taken;
   int          take_cyc[16];
   int          req_cnt;
   int          n2;
   logic [15:0] log2[4];
   logic        got2;
   logic [15:0] pc2_first;
   logic [31:0] ir2_first;

   sisc_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .ir         (ir),
      .ir_valid   (ir_valid),
      .ir_take    (ir_take),
      .pc         (pc),
      .br_taken   (br_taken),
      .br_target  (br_target)
   );

   sisc_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_wrap (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (req2),
      .imem_addr  (addr2),
      .imem_ack   (ack2),
      .imem_rdata (rdata2),
      .ir         (ir2),
      .ir_valid   (ir_valid2),
      .ir_take    (1'b1),
      .pc         (pc2),
      .br_taken   (1'b0),
      .br_target  (16'h0000)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_ack   = force_ack |
                       (imem_req & (wcnt >= lat) & ~(hold_en & (imem_addr == hold_addr)));
   assign imem_rdata = ovr_en ? ovr_dat : (32'h1000_0000 + {16'h0, imem_addr});
   assign ack2       = req2;
   assign rdata2     = 32'h1000_0000 + {16'h0, addr2};

   always @(posedge clk) begin
      if (imem_req && !imem_ack) wcnt <= wcnt + 1;
      else                       wcnt <= 0;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic expect_word(input logic [15:0] a);
      exp_t e;
      e.pc = a;
      e.ir = 32'h1000_0000 + {16'h0, a};
      sb.push_back(e);
   endtask

   // One clock: sample at the falling edge, then advance past the rising edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (imem_req) req_cnt++;
      if (ir_valid && ir_take) begin
         if (sb.size() != 0) e = sb.pop_front();
         else                e = '1;
         chk("sb_take", {16'h0, pc, ir}, {16'h0, e});
         if (n_taken < 16) take_cyc[n_taken] = cyc;
         n_taken++;
      end
      if (req2 && ack2 && n2 < 4) begin
         log2[n2] = addr2;
         n2++;
      end
      if (ir_valid2 && !got2) begin
         got2      = 1'b1;
         pc2_first = pc2;
         ir2_first = ir2;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_taken(input int n, input string tag);
      for (int i = 0; i < 200 && n_taken < n; i++) tick();
      chk(tag, 64'(n_taken), 64'(n));
   endtask

   // Two reset cycles, then release; returns in the first cycle with rst=0.
   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      sb.delete();
      n_taken = 0;
      req_cnt = 0;
      n2      = 0;
      got2    = 1'b0;
      for (int i = 0; i < 4; i++) log2[i] = 16'h5555;
      rst = 1'b0;
      rel = cyc;
   endtask

   initial begin
      rst = 1'b1; ir_take = 1'b0; br_taken = 1'b0; br_target = 16'h0;
      lat = 0; hold_en = 1'b0; hold_addr = 16'h0; force_ack = 1'b0;
      ovr_en = 1'b0; ovr_dat = 32'h0;
      vectors = 0; miscompares = 0; cyc = 0; rel = 0; n_taken = 0; req_cnt = 0;
      n2 = 0; got2 = 1'b0; pc2_first = 16'h0; ir2_first = 32'h0;
      for (int i = 0; i < 16; i++) take_cyc[i] = 0;

      // Reset values, streaming with zero-wait memory, reset-PC wrap
      ir_take = 1'b1;
      do_reset();
      chk("rst_ir",   64'(ir),        64'h0);
      chk("rst_vld",  64'(ir_valid),  64'h0);
      chk("rst_pc",   64'(pc),        64'h0);
      chk("rst_req",  64'(imem_req),  64'h0);
      chk("rst_addr", 64'(imem_addr), 64'h0);
      for (int a = 0; a < 6; a++) expect_word(16'(a));
      tick();
      chk("first_req",  64'(imem_req),  64'h1);
      chk("first_addr", 64'(imem_addr), 64'h0);
      wait_taken(6, "stream_done");
      ir_take = 1'b0;
      chk("stream_lat", 64'(take_cyc[0] - rel), 64'd2);
      for (int k = 1; k < 6; k++)
         chk("stream_rate", 64'(take_cyc[k] - take_cyc[k-1]), 64'(SPACING));
      chk("wrap_addr0", 64'(log2[0]),   64'hFFFF);
      chk("wrap_addr1", 64'(log2[1]),   64'h0000);
      chk("wrap_pc",    64'(pc2_first), 64'hFFFF);
      chk("wrap_ir",    64'(ir2_first), 64'h1000_FFFF);

      // Three-cycle memory wait: request held stable until the ack
      lat = 3;
      ir_take = 1'b1;
      do_reset();
      expect_word(16'h0);
      expect_word(16'h1);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("slow_req",  64'(imem_req),  64'h1);
         chk("slow_addr", 64'(imem_addr), 64'h0);
         chk("slow_vld",  64'(ir_valid),  64'h0);
         tick();
      end
      chk("slow_rise", 64'(ir_valid), 64'h1);
      chk("slow_pc",   64'(pc),       64'h0);
      wait_taken(2, "slow_done");
      ir_take = 1'b0;
      lat = 0;

      // Consumer stall, then branch with no outstanding request
      ovr_en = 1'b1;
      ovr_dat = 32'hDEAD_BEEF;
      do_reset();
      tick();
      tick();
      chk("stall_ir0",  64'(ir),       64'hDEAD_BEEF);
      chk("stall_vld0", 64'(ir_valid), 64'h1);
      req_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_ir",  64'(ir),       64'hDEAD_BEEF);
         chk("stall_pc",  64'(pc),       64'h0);
         chk("stall_vld", 64'(ir_valid), 64'h1);
      end
      chk("stall_reqs", 64'(req_cnt), 64'(STALL_REQS));
      ovr_en = 1'b0;
      expect_word(16'h0080);
      br_target = 16'h0080;
      br_taken = 1'b1;
      tick();
      br_taken = 1'b0;
      chk("br_flush", 64'(ir_valid),  64'h0);
      chk("br_addr",  64'(imem_addr), 64'h0080);
      tick();
      chk("br_vld", 64'(ir_valid), 64'h1);
      chk("br_pc",  64'(pc),       64'h0080);
      ir_take = 1'b1;
      wait_taken(1, "br_done");
      ir_take = 1'b0;

      // Branch while the request to 0x0005 is outstanding and unacked
      hold_en = 1'b1;
      hold_addr = 16'h0005;
      ir_take = 1'b1;
      do_reset();
      for (int a = 0; a < 5; a++) expect_word(16'(a));
      wait_taken(5, "sq_pre");
      tick();
      chk("sq_req",   64'(imem_req),  64'h1);
      chk("sq_addr5", 64'(imem_addr), 64'h0005);
      expect_word(16'h0040);
      expect_word(16'h0041);
      br_target = 16'h0040;
      br_taken = 1'b1;
      tick();
      br_taken = 1'b0;
      chk("sq_keep_req",  64'(imem_req),  64'h1);
      chk("sq_keep_addr", 64'(imem_addr), 64'h0005);
      chk("sq_vld0",      64'(ir_valid),  64'h0);
      hold_en = 1'b0;
      tick();
      chk("sq_new_req",  64'(imem_req),  64'h1);
      chk("sq_new_addr", 64'(imem_addr), 64'h0040);
      tick();
      chk("sq_vld1", 64'(ir_valid), 64'h1);
      chk("sq_pc",   64'(pc),       64'h0040);
      wait_taken(7, "sq_done");
      ir_take = 1'b0;

      // Reset during an outstanding request, then a late ack in IDLE
      hold_en = 1'b1;
      hold_addr = 16'h0003;
      ir_take = 1'b1;
      do_reset();
      for (int a = 0; a < 3; a++) expect_word(16'(a));
      wait_taken(3, "mr_pre");
      tick();
      chk("mr_pre_pc",   64'(pc),        64'h0002);
      chk("mr_pre_addr", 64'(imem_addr), 64'h0003);
      rst = 1'b1;
      tick();
      chk("mr_req",  64'(imem_req),  64'h0);
      chk("mr_vld",  64'(ir_valid),  64'h0);
      chk("mr_pc",   64'(pc),        64'h0);
      chk("mr_addr", 64'(imem_addr), 64'h0);
      rst = 1'b0;
      force_ack = 1'b1;
      ovr_en = 1'b1;
      ovr_dat = 32'hBAD0_0000;
      tick();
      force_ack = 1'b0;
      ovr_en = 1'b0;
      chk("mr_late_vld", 64'(ir_valid),  64'h0);
      chk("mr_re_req",   64'(imem_req),  64'h1);
      chk("mr_re_addr",  64'(imem_addr), 64'h0);
      expect_word(16'h0);
      wait_taken(4, "mr_done");
      ir_take = 1'b0;
      hold_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
